// File: rtl/motion_step_if.sv
// Bundle between the motion command sources and the step scheduler.
// The master side is the set of command sources; the slave side is the scheduler.
interface motion_step_if #(
  parameter int NREQ  = 3,
  parameter int CNT_W = 8
);
  logic                    estop;
  logic [NREQ-1:0]         req;
  logic [NREQ-1:0]         dir_in;
  logic [NREQ*CNT_W-1:0]   steps_in;
  logic [NREQ-1:0]         grant;
  logic [NREQ-1:0]         done;
  logic                    aborted;
  logic                    step;
  logic                    dir;
  logic                    busy;
  logic [CNT_W-1:0]        steps_left;

  modport master (
    output estop, req, dir_in, steps_in,
    input  grant, done, aborted, step, dir, busy, steps_left
  );

  modport slave (
    input  estop, req, dir_in, steps_in,
    output grant, done, aborted, step, dir, busy, steps_left
  );
endinterface

// File: rtl/motion_step_scheduler.sv
// Round-robin owner of the single step/dir driver; sequences one move at a time.
// state | meaning
// IDLE  | no owner; pick the next requester unless estop is high
// RUN   | owner's move in progress, step pulses generated from phase
// DONE  | one-cycle completion (done, optionally aborted) to the owner
module motion_step_scheduler #(
  parameter int NREQ     = 3,
  parameter int CNT_W    = 8,
  parameter int STEP_DIV = 16,
  parameter int PULSE_W  = 4
) (
  input logic          clk,
  input logic          rst,
  motion_step_if.slave bus
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PH_W  = $clog2(STEP_DIV);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PH_W-1:0]   phase;
  logic [NREQ-1:0]   grant_q;
  logic [NREQ-1:0]   done_q;
  logic              aborted_q;
  logic              dir_q;
  logic [CNT_W-1:0]  steps_q;

  logic              found_hi;
  logic              found_any;
  logic [PTR_W-1:0]  hi_idx;
  logic [PTR_W-1:0]  lo_idx;
  logic [PTR_W-1:0]  winner;
  logic [PTR_W-1:0]  winner_next;
  logic [CNT_W-1:0]  sel_steps;
  logic              sel_dir;

  // Two-pass scan: lowest request at or above the pointer, else lowest overall (wrap).
  always_comb begin
    found_hi  = 1'b0;
    found_any = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (bus.req[j]) begin
        found_any = 1'b1;
        lo_idx    = PTR_W'(j);
        if (PTR_W'(j) >= rr_ptr) begin
          found_hi = 1'b1;
          hi_idx   = PTR_W'(j);
        end
      end
    end
    winner      = found_hi ? hi_idx : lo_idx;
    winner_next = (winner == PTR_W'(NREQ - 1)) ? '0 : winner + PTR_W'(1);
  end

  always_comb begin
    sel_steps = '0;
    sel_dir   = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (PTR_W'(j) == winner) begin
        sel_steps = bus.steps_in[j*CNT_W +: CNT_W];
        sel_dir   = bus.dir_in[j];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      phase     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      aborted_q <= 1'b0;
      dir_q     <= 1'b0;
      steps_q   <= '0;
    end else begin
      done_q    <= '0;
      aborted_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.estop && found_any) begin
            state   <= RUN;
            grant_q <= NREQ'(1) << winner;
            dir_q   <= sel_dir;
            steps_q <= sel_steps;
            phase   <= '0;
            rr_ptr  <= winner_next;
          end
        end
        RUN: begin
          if (bus.estop) begin
            state     <= DONE;
            done_q    <= grant_q;
            aborted_q <= 1'b1;
          end else if (steps_q == '0) begin
            state  <= DONE;
            done_q <= grant_q;
          end else if (phase == PH_W'(STEP_DIV - 1)) begin
            // The last decrement goes straight to DONE so done lands N*STEP_DIV after grant.
            phase   <= '0;
            steps_q <= steps_q - CNT_W'(1);
            if (steps_q == CNT_W'(1)) begin
              state  <= DONE;
              done_q <= grant_q;
            end
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        DONE: begin
          state   <= IDLE;
          grant_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.done       = done_q;
  assign bus.aborted    = aborted_q;
  assign bus.dir        = dir_q;
  assign bus.steps_left = steps_q;
  assign bus.busy       = (state != IDLE);
  assign bus.step       = (state == RUN) && (phase < PH_W'(PULSE_W)) && (steps_q != '0);
endmodule

// File: tb/tb_motion_step_scheduler.sv
// Bench for motion_step_scheduler: directed scenarios plus a randomized run
// checked against a round-robin / step-timeline model of the scheduler's rules.
module tb_motion_step_scheduler;
  localparam int NREQ     = 3;
  localparam int CNT_W    = 8;
  localparam int STEP_DIV = 16;
  localparam int PULSE_W  = 4;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   rr_model = 0;

  logic [NREQ-1:0]  req_v = '0;
  logic [NREQ-1:0]  dir_v = '0;
  logic [CNT_W-1:0] st_v [NREQ];
  logic             estop_v = 1'b0;

  motion_step_if #(.NREQ(NREQ), .CNT_W(CNT_W)) bus ();

  motion_step_scheduler #(
    .NREQ(NREQ), .CNT_W(CNT_W), .STEP_DIV(STEP_DIV), .PULSE_W(PULSE_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.req    = req_v;
  assign bus.dir_in = dir_v;
  assign bus.estop  = estop_v;
  always_comb begin
    bus.steps_in = '0;
    for (int i = 0; i < NREQ; i++) bus.steps_in[i*CNT_W +: CNT_W] = st_v[i];
  end

  // Reference model: round-robin choice, step timeline and move length.
  function automatic int pick(logic [NREQ-1:0] r, int p);
    for (int k = 0; k < NREQ; k++)
      if (((r >> ((p + k) % NREQ)) & 1) != 0) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic model_step(int c, int n);
    return (c < n * STEP_DIV) && ((c % STEP_DIV) < PULSE_W);
  endfunction

  function automatic int model_len(int n);
    return (n == 0) ? 1 : n * STEP_DIV;
  endfunction

  function automatic logic [NREQ-1:0] oh(int i);
    return NREQ'(1 << i);
  endfunction

  task automatic raise(int i, bit d, int n);
    st_v[i] = CNT_W'(n);
    dir_v   = d ? (dir_v | oh(i)) : (dir_v & ~oh(i));
    req_v   = req_v | oh(i);
  endtask

  task automatic drop(int i);
    req_v = req_v & ~oh(i);
  endtask

  task automatic wait_grant(input int limit, output int waited);
    waited = 0;
    while (bus.grant == '0 && waited < limit) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic wait_done(input int limit, output int waited);
    waited = 0;
    while (bus.done == '0 && waited < limit) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rr_model = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({bus.grant, bus.done, bus.aborted, bus.step, bus.dir, bus.busy, bus.steps_left} !== '0) begin
      fails++;
      $display("FAIL reset_outputs grant=%b done=%b ab=%b step=%b dir=%b busy=%b left=%0d want all 0",
               bus.grant, bus.done, bus.aborted, bus.step, bus.dir, bus.busy, bus.steps_left);
    end
  endtask

  task automatic test_single_move();
    int rises, highs;
    logic prev;
    raise(0, 1'b1, 3);
    @(negedge clk);
    rises = 0; highs = 0; prev = 1'b0;
    tests++;
    if (bus.grant !== 3'b001) begin
      fails++; $display("FAIL single_grant got %b want 001", bus.grant);
    end
    for (int c = 0; c < 48; c++) begin
      tests++;
      if (bus.grant !== 3'b001 || bus.step !== model_step(c, 3) || bus.dir !== 1'b1 ||
          bus.steps_left !== CNT_W'(3 - c / STEP_DIV) || bus.done !== '0 || bus.busy !== 1'b1) begin
        fails++;
        $display("FAIL single_cycle c=%0d grant=%b step=%b left=%0d dir=%b done=%b want step=%b left=%0d",
                 c, bus.grant, bus.step, bus.steps_left, bus.dir, bus.done, model_step(c, 3), 3 - c / STEP_DIV);
      end
      if (bus.step === 1'b1 && prev === 1'b0) rises++;
      if (bus.step === 1'b1) highs++;
      prev = bus.step;
      @(negedge clk);
    end
    tests++;
    if (rises != 3 || highs != 12) begin
      fails++; $display("FAIL single_pulses rises=%0d highs=%0d want 3 and 12", rises, highs);
    end
    tests++;
    if (bus.done !== 3'b001 || bus.aborted !== 1'b0 || bus.step !== 1'b0 || bus.grant !== 3'b001) begin
      fails++;
      $display("FAIL single_done done=%b ab=%b step=%b grant=%b want 001 0 0 001",
               bus.done, bus.aborted, bus.step, bus.grant);
    end
    drop(0);
    @(negedge clk);
    tests++;
    if (bus.grant !== '0 || bus.busy !== 1'b0 || bus.done !== '0) begin
      fails++; $display("FAIL single_idle grant=%b busy=%b done=%b want 0", bus.grant, bus.busy, bus.done);
    end
    rr_model = 1;
  endtask

  task automatic test_zero_steps();
    raise(1, 1'b0, 0);
    @(negedge clk);
    tests++;
    if (bus.grant !== 3'b010 || bus.step !== 1'b0 || bus.steps_left !== '0 || bus.done !== '0) begin
      fails++;
      $display("FAIL zero_run grant=%b step=%b left=%0d done=%b want 010 0 0 000",
               bus.grant, bus.step, bus.steps_left, bus.done);
    end
    @(negedge clk);
    tests++;
    if (bus.done !== 3'b010 || bus.grant !== 3'b010 || bus.step !== 1'b0 || bus.aborted !== 1'b0) begin
      fails++;
      $display("FAIL zero_done done=%b grant=%b step=%b ab=%b want 010 010 0 0",
               bus.done, bus.grant, bus.step, bus.aborted);
    end
    drop(1);
    @(negedge clk);
    rr_model = 2;
  endtask

  task automatic test_contention();
    int order [4] = '{0, 1, 2, 0};
    int waited;
    do_reset();
    raise(0, 1'b0, 1); raise(1, 1'b1, 1); raise(2, 1'b0, 1);
    for (int m = 0; m < 4; m++) begin
      wait_grant(8, waited);
      tests++;
      if (bus.grant !== oh(order[m])) begin
        fails++; $display("FAIL contention_grant m=%0d got %b want %b", m, bus.grant, oh(order[m]));
      end
      if (m == 1) raise(0, 1'b1, 1);
      wait_done(40, waited);
      tests++;
      if (bus.done !== oh(order[m]) || waited != STEP_DIV) begin
        fails++;
        $display("FAIL contention_done m=%0d done=%b after %0d want %b after %0d",
                 m, bus.done, waited, oh(order[m]), STEP_DIV);
      end
      drop(order[m]);
      @(negedge clk);
    end
    rr_model = 1;
  endtask

  task automatic test_estop();
    int waited;
    logic bad;
    raise(2, 1'b0, 5);
    wait_grant(8, waited);
    tests++;
    if (bus.grant !== 3'b100) begin
      fails++; $display("FAIL estop_grant got %b want 100", bus.grant);
    end
    repeat (STEP_DIV + 1) @(negedge clk);
    tests++;
    if (bus.step !== 1'b1 || bus.steps_left !== CNT_W'(4)) begin
      fails++; $display("FAIL estop_pre step=%b left=%0d want 1 4", bus.step, bus.steps_left);
    end
    estop_v = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.step !== 1'b0 || bus.done !== 3'b100 || bus.aborted !== 1'b1 || bus.steps_left !== CNT_W'(4)) begin
      fails++;
      $display("FAIL estop_abort step=%b done=%b ab=%b left=%0d want 0 100 1 4",
               bus.step, bus.done, bus.aborted, bus.steps_left);
    end
    drop(2);
    raise(0, 1'b1, 1);
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.grant !== '0 || bus.aborted !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad !== 1'b0) begin
      fails++; $display("FAIL estop_hold grant=%b ab=%b want no grant while estop", bus.grant, bus.aborted);
    end
    estop_v = 1'b0;
    wait_grant(4, waited);
    tests++;
    if (bus.grant !== oh(pick(3'b001, 0))) begin
      fails++; $display("FAIL estop_release got %b want 001", bus.grant);
    end
    wait_done(40, waited);
    tests++;
    if (bus.done !== 3'b001 || bus.aborted !== 1'b0 || waited != STEP_DIV) begin
      fails++;
      $display("FAIL estop_after done=%b ab=%b after %0d want 001 0 after %0d", bus.done, bus.aborted, waited, STEP_DIV);
    end
    drop(0);
    @(negedge clk);
    rr_model = 1;
  endtask

  task automatic test_reset_mid_move();
    int waited;
    raise(1, 1'b1, 4);
    wait_grant(8, waited);
    tests++;
    if (bus.grant !== 3'b010) begin
      fails++; $display("FAIL rstmid_grant got %b want 010", bus.grant);
    end
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({bus.grant, bus.done, bus.aborted, bus.step, bus.dir, bus.busy, bus.steps_left} !== '0) begin
      fails++;
      $display("FAIL rstmid_async grant=%b done=%b ab=%b step=%b dir=%b busy=%b left=%0d want all 0",
               bus.grant, bus.done, bus.aborted, bus.step, bus.dir, bus.busy, bus.steps_left);
    end
    raise(2, 1'b0, 1);
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (bus.done !== '0 || bus.aborted !== 1'b0) begin
      fails++; $display("FAIL rstmid_nodone done=%b ab=%b want 000 0", bus.done, bus.aborted);
    end
    rr_model = 0;
    wait_grant(4, waited);
    tests++;
    if (bus.grant !== oh(pick(req_v, rr_model))) begin
      fails++; $display("FAIL rstmid_regrant got %b want %b", bus.grant, oh(pick(req_v, rr_model)));
    end
    wait_done(100, waited);
    tests++;
    if (bus.done !== 3'b010 || waited != 4 * STEP_DIV) begin
      fails++; $display("FAIL rstmid_done done=%b after %0d want 010 after %0d", bus.done, waited, 4 * STEP_DIV);
    end
    drop(1);
    @(negedge clk);
    wait_grant(4, waited);
    wait_done(40, waited);
    tests++;
    if (bus.done !== 3'b100) begin
      fails++; $display("FAIL rstmid_second done=%b want 100", bus.done);
    end
    drop(2);
    @(negedge clk);
    rr_model = 0;
  endtask

  task automatic test_back_to_back();
    int waited;
    raise(2, 1'b0, 1);
    wait_grant(8, waited);
    tests++;
    if (bus.grant !== 3'b100) begin
      fails++; $display("FAIL b2b_first got %b want 100", bus.grant);
    end
    raise(0, 1'b1, 2);
    wait_done(40, waited);
    tests++;
    if (bus.done !== 3'b100) begin
      fails++; $display("FAIL b2b_done2 done=%b want 100", bus.done);
    end
    @(negedge clk);
    tests++;
    if (bus.grant !== '0) begin
      fails++; $display("FAIL b2b_gap grant=%b want 000", bus.grant);
    end
    @(negedge clk);
    tests++;
    if (bus.grant !== 3'b001 || bus.dir !== 1'b1 || bus.steps_left !== CNT_W'(2)) begin
      fails++;
      $display("FAIL b2b_second grant=%b dir=%b left=%0d want 001 1 2", bus.grant, bus.dir, bus.steps_left);
    end
    wait_done(80, waited);
    tests++;
    if (bus.done !== 3'b001 || waited != 2 * STEP_DIV) begin
      fails++; $display("FAIL b2b_done0 done=%b after %0d want 001 after %0d", bus.done, waited, 2 * STEP_DIV);
    end
    drop(0);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (bus.grant !== 3'b100) begin
      fails++; $display("FAIL b2b_third grant=%b want 100", bus.grant);
    end
    wait_done(40, waited);
    drop(2);
    @(negedge clk);
    rr_model = 0;
  endtask

  task automatic test_random();
    int w, n, len, waited, k;
    logic d;
    logic [NREQ-1:0] g;
    for (int m = 0; m < 40; m++) begin
      if (req_v == '0) raise($urandom_range(NREQ - 1), 1'($urandom_range(1)), $urandom_range(3));
      w = pick(req_v, rr_model);
      n = int'(st_v[w]);
      d = ((dir_v >> w) & 1) != 0;
      g = oh(w);
      wait_grant(8, waited);
      tests++;
      if (bus.grant !== g) begin
        fails++; $display("FAIL rand_grant m=%0d got %b want %b", m, bus.grant, g);
      end
      len = model_len(n);
      for (int c = 0; c < len; c++) begin
        tests++;
        if (bus.grant !== g || bus.step !== model_step(c, n) || bus.dir !== d ||
            bus.steps_left !== CNT_W'(n - c / STEP_DIV) || bus.done !== '0) begin
          fails++;
          $display("FAIL rand_cycle m=%0d c=%0d grant=%b step=%b left=%0d dir=%b want %b %b %0d %b",
                   m, c, bus.grant, bus.step, bus.steps_left, bus.dir, g, model_step(c, n), n - c / STEP_DIV, d);
        end
        if (c == 2) begin
          st_v[w] = CNT_W'($urandom_range(3));
          dir_v   = dir_v ^ g;
        end
        if (c == 3 && $urandom_range(1) == 1) begin
          k = $urandom_range(NREQ - 1);
          if (((req_v >> k) & 1) == 0) raise(k, 1'($urandom_range(1)), $urandom_range(3));
        end
        @(negedge clk);
      end
      tests++;
      if (bus.done !== g || bus.aborted !== 1'b0 || bus.step !== 1'b0) begin
        fails++;
        $display("FAIL rand_done m=%0d done=%b ab=%b step=%b want %b 0 0", m, bus.done, bus.aborted, bus.step, g);
      end
      rr_model = (w + 1) % NREQ;
      if ($urandom_range(1) == 0) drop(w);
      @(negedge clk);
    end
    req_v = '0;
    repeat (60) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) st_v[i] = '0;
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_move();
    test_zero_steps();
    test_contention();
    test_estop();
    test_reset_mid_move();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
